mips_io_port: RTL and testbench
===============================

Name: mips_io_port

Overview:
- Memory-mapped I/O peripheral that sits directly downstream of the single-cycle MIPS datapath.
- Consumes the ALU result as the effective address, plus the MemRead/MemWrite strobes and rt write data for lw/sw.
- Drives the processor's 32-bit PortOut pins and returns read data to the write-back mux.
- Synchronizes the 8-bit PortIn pins, detects changes, latches new values and reports them through a read-to-clear status register.

Parameters:
- PORT_OUT_ADDR, 32'h1001_0024, word address of the PortOut register (R/W).
- PORT_IN_ADDR, 32'h1001_0028, word address of the latched PortIn value (RO; a read clears NEW).
- STATUS_ADDR, 32'h1001_002C, word address of the status register.
- IN_WIDTH, 8, PortIn width; must be 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  lw in current cycle.
- MemWrite  input  1  sw in current cycle.
- Address  input  32  effective address (ALU result).
- WriteData  input  32  store data (ReadData2).
- PortIn  input  IN_WIDTH  asynchronous external pins.
- ReadData  output  32  combinational read data.
- IOSelect  output  1  Address hits one of the three registers; the datapath uses it to pick ReadData over data memory.
- PortOut  output  32  registered output port.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset takes effect only at a rising edge with reset=1 and overrides all other activity in that cycle.
- Reset values: PortOut=0, sync stages=0, InLatch=0, NEW=0, OVR=0, IE=0. ReadData and IOSelect are combinational: 0 for any unmapped address.
- Address decode:
  - Full 32-bit compare; Address[1:0] must be 00, otherwise there is no hit.
  - IOSelect=1 when Address equals any of the three addresses, independent of MemRead/MemWrite.
- Read (combinational, zero latency):
  - ReadData=PortOut at PORT_OUT_ADDR.
  - ReadData={zero-extend, InLatch} at PORT_IN_ADDR.
  - ReadData={29'b0, IE, OVR, NEW} at STATUS_ADDR.
  - ReadData=0 when there is no hit. ReadData is driven regardless of MemRead.
- Writes (take effect at the edge):
  - sw to PORT_OUT_ADDR: PortOut<=WriteData, visible the cycle after.
  - sw to STATUS_ADDR: IE<=WriteData[2]; WriteData[1]=1 clears OVR (write-1-to-clear); WriteData[0] is ignored.
  - sw to PORT_IN_ADDR is ignored.
- Input path:
  - Two-flop synchronizer S1<=PortIn, S2<=S1.
  - Change detect: when S2!=InLatch, InLatch<=S2 at the next edge.
  - A pin change that is stable before edge k gives S2 valid after edge k+1 and InLatch/NEW valid after edge k+2.
- NEW flag:
  - Set on every InLatch capture.
  - Cleared at the edge where MemRead=1 and Address=PORT_IN_ADDR.
  - Simultaneous capture and clearing read: the capture wins, so NEW stays 1 and the read returns the old InLatch.
- OVR flag:
  - Set when a capture occurs while NEW=1 and no clearing read happens in the same cycle.
  - Sticky until cleared by W1C or reset.
  - Simultaneous set and W1C: the set wins.
- MemRead and MemWrite both asserted is illegal; the write is performed and the read side effect (NEW clear) is suppressed.
- No handshake stalls: every access completes in one cycle.

Optional Feature:
- Macro MIPS_IO_PORT_IRQ_EN.
- Defined:
  - Adds output port Irq (1 bit), registered: Irq<=IE & (NEW|OVR) each edge; reset value 0.
  - Irq deasserts the edge after NEW and OVR are both clear or IE is 0.
- Undefined:
  - Irq port is absent.
  - The IE bit still exists as a read/write storage bit with no effect.

Test Plan:
- Reset check: assert reset 2 cycles with PortIn=8'hA5 held -> PortOut=0, status read=0; after release, NEW=1 and InLatch=8'hA5 3 edges later.
- PortOut write: sw 32'hDEAD_BEEF to 32'h1001_0024 -> PortOut=DEADBEEF next cycle; lw same address returns DEADBEEF; IOSelect=1; address 32'h1001_0030 gives IOSelect=0, ReadData=0.
- Read-to-clear: PortIn 00->3C, wait 3 edges -> status=1; lw 32'h1001_0028 returns 0000003C; following status read = 0.
- Overrun: PortIn 3C->11, then ->22 with no read -> status=3 (NEW|OVR), InLatch=22; sw 2 to STATUS -> status=1.
- Collision: a capture of 8'h55 coincides with a clearing lw of PORT_IN -> lw returns the old value, NEW stays 1, OVR unchanged, next lw returns 55.
- With MIPS_IO_PORT_IRQ_EN: sw 4 to STATUS, then a PortIn change -> Irq=1 one edge after NEW; lw PORT_IN -> Irq=0 one edge after NEW clears; a reset mid-assertion drops Irq at that edge.

Source files
------------

// File: rtl/mips_io_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_io_port_if
// Purpose  : Load/store bus between the single-cycle MIPS datapath and the
//            memory-mapped I/O port.
// Signals  : MemRead   - lw in the current cycle
//            MemWrite  - sw in the current cycle
//            Address   - effective address (ALU result)
//            WriteData - store data (rt / ReadData2)
//            ReadData  - combinational read data back to the write-back mux
//            IOSelect  - Address hits an I/O register
// Modports : master (datapath side), slave (peripheral side)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_io_port_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IOSelect;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, IOSelect
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, IOSelect
  );
endinterface
`default_nettype wire

// File: rtl/mips_io_port.sv
`default_nettype none
// ============================================================================
// Module   : mips_io_port
// Purpose  : Memory-mapped I/O peripheral for the single-cycle MIPS datapath.
//            Registered 32-bit PortOut, synchronised and change-latched PortIn,
//            and a status register {IE, OVR, NEW} with read-to-clear NEW and
//            write-1-to-clear OVR.
// Ports    : clk     - system clock, rising edge
//            reset   - synchronous, active-high
//            bus     - mips_io_port_if.slave load/store bus
//            PortIn  - asynchronous external input pins (IN_WIDTH)
//            PortOut - registered output port (32)
//            Irq     - registered interrupt request (only with
//                      MIPS_IO_PORT_IRQ_EN defined)
// Options  : `define MIPS_IO_PORT_IRQ_EN adds the Irq output. Without it the
//            IE bit is plain read/write storage.
// Revision : 1.0 - initial release
// ============================================================================
module mips_io_port #(
  parameter logic [31:0] PORT_OUT_ADDR = 32'h1001_0024,
  parameter logic [31:0] PORT_IN_ADDR  = 32'h1001_0028,
  parameter logic [31:0] STATUS_ADDR   = 32'h1001_002C,
  parameter int          IN_WIDTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  mips_io_port_if.slave       bus,
  input  logic [IN_WIDTH-1:0] PortIn,
`ifdef MIPS_IO_PORT_IRQ_EN
  output logic                Irq,
`endif
  output logic [31:0]         PortOut
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]         r_portOut;
  logic [IN_WIDTH-1:0] r_sync1;
  logic [IN_WIDTH-1:0] r_sync2;
  logic [IN_WIDTH-1:0] r_inLatch;
  logic                r_new;
  logic                r_ovr;
  logic                r_ie;

  // --------------------------------------------------------------------------
  // Address decode: full 32-bit compare, word-aligned only
  // --------------------------------------------------------------------------
  logic w_aligned;
  logic w_hitOut;
  logic w_hitIn;
  logic w_hitStat;

  assign w_aligned = (bus.Address[1:0] == 2'b00);
  assign w_hitOut  = w_aligned && (bus.Address == PORT_OUT_ADDR);
  assign w_hitIn   = w_aligned && (bus.Address == PORT_IN_ADDR);
  assign w_hitStat = w_aligned && (bus.Address == STATUS_ADDR);

  assign bus.IOSelect = w_hitOut || w_hitIn || w_hitStat;

  // --------------------------------------------------------------------------
  // Read path (combinational, independent of MemRead)
  // --------------------------------------------------------------------------
  logic [31:0] w_inExt;

  generate
    if (IN_WIDTH < 32) begin : g_inZext
      assign w_inExt = {{(32-IN_WIDTH){1'b0}}, r_inLatch};
    end else begin : g_inFull
      assign w_inExt = r_inLatch;
    end
  endgenerate

  always_comb begin
    bus.ReadData = 32'h0;
    if (w_hitOut)       bus.ReadData = r_portOut;
    else if (w_hitIn)   bus.ReadData = w_inExt;
    else if (w_hitStat) bus.ReadData = {29'b0, r_ie, r_ovr, r_new};
  end

  // --------------------------------------------------------------------------
  // Control strobes
  // --------------------------------------------------------------------------
  logic w_wrOut;
  logic w_wrStat;
  logic w_clrRead;
  logic w_w1cOvr;
  logic w_capture;

  assign w_wrOut   = bus.MemWrite && w_hitOut;
  assign w_wrStat  = bus.MemWrite && w_hitStat;
  // An illegal simultaneous read+write keeps the write and drops the
  // read side effect.
  assign w_clrRead = bus.MemRead && !bus.MemWrite && w_hitIn;
  assign w_w1cOvr  = w_wrStat && bus.WriteData[1];
  assign w_capture = (r_sync2 != r_inLatch);

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_portOut <= 32'h0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_inLatch <= '0;
      r_new     <= 1'b0;
      r_ovr     <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;

      if (w_capture) r_inLatch <= r_sync2;
      if (w_wrOut)   r_portOut <= bus.WriteData;
      if (w_wrStat)  r_ie      <= bus.WriteData[2];

      // A capture beats a coincident clearing read: the reader saw the
      // old value, so the new one must still be flagged.
      if (w_capture)      r_new <= 1'b1;
      else if (w_clrRead) r_new <= 1'b0;

      // Overrun only when an unread value is overwritten; a set beats a
      // coincident W1C so no overrun is silently lost.
      if (w_capture && r_new && !w_clrRead) r_ovr <= 1'b1;
      else if (w_w1cOvr)                    r_ovr <= 1'b0;
    end
  end

  assign PortOut = r_portOut;

`ifdef MIPS_IO_PORT_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_ie && (r_new || r_ovr);
  end

  assign Irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_io_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_io_port
// Purpose  : Self-checking bench for mips_io_port. Expected values are queued
//            when stimulus is driven and compared against the DUT at the
//            sample point; a vector table covers decode/read/write cases and
//            hand-written sequences cover input-path timing, read-to-clear,
//            overrun, collisions and the optional Irq output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_io_port;

  localparam logic [31:0] A_OUT  = 32'h1001_0024;
  localparam logic [31:0] A_IN   = 32'h1001_0028;
  localparam logic [31:0] A_STAT = 32'h1001_002C;

  localparam int K_RD  = 0;
  localparam int K_SEL = 1;
  localparam int K_OUT = 2;
  localparam int K_IRQ = 3;

  logic       clk;
  logic       reset;
  logic [7:0] PortIn;
  logic [31:0] PortOut;
`ifdef MIPS_IO_PORT_IRQ_EN
  logic       Irq;
`endif

  mips_io_port_if bus ();

  mips_io_port dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .PortIn  (PortIn),
`ifdef MIPS_IO_PORT_IRQ_EN
    .Irq     (Irq),
`endif
    .PortOut (PortOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expSel;
    logic [31:0] expOut;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[14];
  int   nCompared   = 0;
  int   nMismatched = 0;

  function automatic logic [31:0] actualOf(int kind);
    case (kind)
      K_RD:    return bus.ReadData;
      K_SEL:   return {31'b0, bus.IOSelect};
      K_OUT:   return PortOut;
`ifdef MIPS_IO_PORT_IRQ_EN
      K_IRQ:   return {31'b0, Irq};
`endif
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Address   = addr;
    bus.WriteData = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic expectVal(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = v;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic checkAll();
    exp_t        e;
    logic [31:0] act;
    #2;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actualOf(e.kind);
      nCompared++;
      if (act !== e.val) begin
        nMismatched++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Non-destructive status peek (MemRead=0 leaves NEW alone).
  task automatic peekStatus(input string name, input logic [31:0] v);
    drive(1'b0, 1'b0, A_STAT, 32'h0);
    expectVal(name, K_RD, v);
    checkAll();
    idle();
  endtask

  task automatic peekIn(input string name, input logic [31:0] v);
    drive(1'b0, 1'b0, A_IN, 32'h0);
    expectVal(name, K_RD, v);
    checkAll();
    idle();
  endtask

  // Clearing lw of PORT_IN: returns the current latch, clears NEW at the edge.
  task automatic readIn(input string name, input logic [31:0] v);
    drive(1'b1, 1'b0, A_IN, 32'h0);
    expectVal(name, K_RD, v);
    checkAll();
    tick();
    idle();
  endtask

  task automatic swStatus(input logic [31:0] v);
    drive(1'b0, 1'b1, A_STAT, v);
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{"lw_out",          1'b1, 1'b0, A_OUT,         32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[1]  = '{"unmapped_30",     1'b1, 1'b0, 32'h1001_0030, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{"misaligned_26",   1'b1, 1'b0, 32'h1001_0026, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{"misaligned_25",   1'b1, 1'b0, 32'h1001_0025, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[4]  = '{"upper_bits",      1'b1, 1'b0, 32'h0000_0024, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[5]  = '{"idle_sel",        1'b0, 1'b0, A_OUT,         32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[6]  = '{"sw_unmapped",     1'b0, 1'b1, 32'h1001_0030, 32'h1234_5678, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[7]  = '{"out_after_unmap", 1'b0, 1'b0, A_OUT,         32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[8]  = '{"sw_portin",       1'b0, 1'b1, A_IN,          32'hFFFF_FFFF, 32'h0000_00A5, 1'b1, 32'hDEAD_BEEF};
    tbl[9]  = '{"in_after_sw",     1'b0, 1'b0, A_IN,          32'h0,         32'h0000_00A5, 1'b1, 32'hDEAD_BEEF};
    tbl[10] = '{"sw_stat_bit0",    1'b0, 1'b1, A_STAT,        32'h0000_0001, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[11] = '{"stat_after_bit0", 1'b0, 1'b0, A_STAT,        32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[12] = '{"sw_misaligned",   1'b0, 1'b1, 32'h1001_0025, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[13] = '{"out_after_mis",   1'b0, 1'b0, A_OUT,         32'h0,         32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};

    // ---------------- reset and first capture ----------------
    idle();
    reset  = 1'b1;
    PortIn = 8'hA5;
    tick(2);
    expectVal("rst_portout", K_OUT, 32'h0);
`ifdef MIPS_IO_PORT_IRQ_EN
    expectVal("rst_irq", K_IRQ, 32'h0);
`endif
    checkAll();
    peekStatus("rst_status", 32'h0);
    reset = 1'b0;
    tick(2);
    peekStatus("rst_status_e2", 32'h0);
    tick();
    peekStatus("rst_status_e3", 32'h1);
    peekIn("rst_inlatch", 32'h0000_00A5);
    readIn("rst_clear_rd", 32'h0000_00A5);
    peekStatus("rst_cleared", 32'h0);

    // ---------------- PortOut write ----------------
    drive(1'b0, 1'b1, A_OUT, 32'hDEAD_BEEF);
    expectVal("out_pre_edge", K_OUT, 32'h0);
    expectVal("out_sel", K_SEL, 32'h1);
    checkAll();
    tick();
    idle();
    expectVal("out_post_edge", K_OUT, 32'hDEAD_BEEF);
    checkAll();

    // ---------------- decode / access table ----------------
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      expectVal({tbl[i].name, "_rd"},  K_RD,  tbl[i].expRd);
      expectVal({tbl[i].name, "_sel"}, K_SEL, {31'b0, tbl[i].expSel});
      expectVal({tbl[i].name, "_out"}, K_OUT, tbl[i].expOut);
      checkAll();
      tick();
    end
    idle();

    // ---------------- read-to-clear ----------------
    PortIn = 8'h00;
    tick(3);
    peekStatus("rtc_new00", 32'h1);
    readIn("rtc_rd00", 32'h0);
    PortIn = 8'h3C;
    tick(2);
    peekStatus("rtc_not_yet", 32'h0);
    tick();
    peekStatus("rtc_new3c", 32'h1);
    readIn("rtc_rd3c", 32'h0000_003C);
    peekStatus("rtc_cleared", 32'h0);

    // ---------------- overrun ----------------
    PortIn = 8'h11;
    tick(3);
    peekStatus("ovr_first", 32'h1);
    PortIn = 8'h22;
    tick(3);
    peekStatus("ovr_set", 32'h3);
    peekIn("ovr_latch22", 32'h0000_0022);
    swStatus(32'h2);
    peekStatus("ovr_w1c", 32'h1);
    // Illegal MemRead+MemWrite on PORT_IN: NEW must not clear.
    drive(1'b1, 1'b1, A_IN, 32'h0);
    tick();
    idle();
    peekStatus("illegal_rdwr", 32'h1);
    readIn("ovr_rd22", 32'h0000_0022);
    peekStatus("ovr_cleared", 32'h0);

    // ---------------- capture / clearing-read collision ----------------
    PortIn = 8'h66;
    tick(3);
    peekStatus("col_new66", 32'h1);
    PortIn = 8'h55;
    tick(2);
    readIn("col_old", 32'h0000_0066);
    peekStatus("col_new_kept", 32'h1);
    readIn("col_rd55", 32'h0000_0055);
    peekStatus("col_cleared", 32'h0);

    // ---------------- OVR set beats W1C ----------------
    PortIn = 8'h77;
    tick(3);
    PortIn = 8'h88;
    tick(2);
    swStatus(32'h2);
    peekStatus("setwin_ovr", 32'h3);
    swStatus(32'h2);
    peekStatus("setwin_w1c", 32'h1);
    readIn("setwin_rd88", 32'h0000_0088);
    peekStatus("setwin_clear", 32'h0);

    // ---------------- IE bit and Irq ----------------
    swStatus(32'h4);
    peekStatus("ie_set", 32'h4);
    PortIn = 8'h99;
    tick(3);
    peekStatus("ie_new", 32'h5);
`ifdef MIPS_IO_PORT_IRQ_EN
    expectVal("irq_lag", K_IRQ, 32'h0);
    checkAll();
    tick();
    expectVal("irq_on", K_IRQ, 32'h1);
    checkAll();
`endif
    readIn("ie_rd99", 32'h0000_0099);
    peekStatus("ie_cleared", 32'h4);
`ifdef MIPS_IO_PORT_IRQ_EN
    expectVal("irq_hold", K_IRQ, 32'h1);
    checkAll();
    tick();
    expectVal("irq_off", K_IRQ, 32'h0);
    checkAll();
    PortIn = 8'h5A;
    tick(4);
    expectVal("irq_on2", K_IRQ, 32'h1);
    checkAll();
`endif

    // ---------------- reset mid-operation ----------------
    reset = 1'b1;
    tick();
`ifdef MIPS_IO_PORT_IRQ_EN
    expectVal("rst2_irq", K_IRQ, 32'h0);
`endif
    expectVal("rst2_portout", K_OUT, 32'h0);
    checkAll();
    peekStatus("rst2_status", 32'h0);
    peekIn("rst2_inlatch", 32'h0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
